turbo_encode: RTL and testbench

Rate-1/3 turbo encoder that produces the systematic and two parity streams consumed by the turbo decoder path. It accepts a block of K information bits serially, buffers them, and emits one (systematic, parity1, parity2) triple per output handshake. Parity1 comes from constituent RSC encoder 1 on natural-order bits. Parity2 comes from RSC encoder 2 on QPP-interleaved bits. Each block ends with 6 trellis-termination triples.

---
 rtl/turbo_pkg.sv | 10 +
 rtl/turbo_encode_if.sv | 21 ++
 rtl/turbo_encode_rsc.sv | 33 +++
 rtl/turbo_encode.sv | 157 +++++++++++++++
 tb/tb_turbo_encode.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// turbo_pkg: shared constants and types for the rate-1/3 turbo encoder.
package turbo_pkg;
    localparam int K_DEF = 40;
    localparam int F1_DEF = 3;
    localparam int F2_DEF = 10;
    localparam int TAIL_LEN = 3;
    localparam logic [3:0] FB_TAPS = 4'o13;
    localparam logic [3:0] PAR_TAPS = 4'o15;
    typedef enum logic [1:0] {LOAD, ENC, TAIL1, TAIL2} state_e;
endpackage

// File: rtl/turbo_encode_if.sv
// turbo_encode_if: serial bit input and triple output handshakes of the turbo encoder.
interface turbo_encode_if;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_sys;
    logic out_p1;
    logic out_p2;
    logic out_last;
    logic busy;
    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_sys, out_p1, out_p2, out_last, busy
    );
    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_sys, out_p1, out_p2, out_last, busy
    );
endinterface

// File: rtl/turbo_encode_rsc.sv
// rsc_enc: 8-state recursive systematic convolutional encoder (feedback 13, parity 15).
// In tail mode the input is replaced by the feedback so the state drains to zero.
module rsc_enc
    import turbo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic term_i,
    input  logic clr_i,
    input  logic u_i,
    output logic sys_o,
    output logic z_o
);
    logic [2:0] s_q;
    logic       fb;
    logic       a;

    // s_q = {d1, d2, d3}
    always_comb begin
        fb    = ^(s_q & FB_TAPS[2:0]);
        sys_o = term_i ? fb : u_i;
        a     = sys_o ^ fb;
        z_o   = a ^ ^(s_q & PAR_TAPS[2:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_i)
            s_q <= '0;
        else if (en_i)
            s_q <= {a, s_q[2:1]};
    end
endmodule

// File: rtl/turbo_encode.sv
// turbo_encode: rate-1/3 turbo encoder with single block buffer and QPP interleaver.
// The output register holds the triple of the step already applied to the RSC states.
module turbo_encode
    import turbo_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int F1 = F1_DEF,
    parameter int F2 = F2_DEF
) (
    input logic           clk,
    input logic           rst,
    turbo_encode_if.slave bus_if
);
    localparam int AW = $clog2(K);
    localparam int W  = AW + 1;
    localparam logic [W-1:0] G0 = W'((F1 + F2) % K);
    localparam logic [W-1:0] DG = W'((2 * F2) % K);
    localparam logic [W-1:0] KW = W'(K);
    localparam logic [W-1:0] KL = W'(K - 1);
    localparam logic [W-1:0] TL = W'(TAIL_LEN - 1);

    state_e         st_q;
    state_e         nst;
    logic [W-1:0]   cnt_q;
    logic [W-1:0]   k_q;
    logic [W-1:0]   nk;
    logic [W-1:0]   pi_q;
    logic [W-1:0]   g_q;
    logic [W-1:0]   pi_sum;
    logic [W-1:0]   g_sum;
    logic [W-1:0]   pi_d;
    logic [W-1:0]   g_d;
    logic [K-1:0]   mem_q;
    logic           accept;
    logic           fire;
    logic           done;
    logic           step;
    logic           ov_q;
    logic           sys_q;
    logic           p1_q;
    logic           p2_q;
    logic           last_q;
    logic           u1;
    logic           u2;
    logic           sys1;
    logic           sys2;
    logic           z1;
    logic           z2;

    assign accept = bus_if.in_valid && st_q == LOAD;
    assign fire   = ov_q && bus_if.out_ready;
    assign done   = fire && st_q == TAIL2 && k_q == TL;
    assign step   = (accept && cnt_q == KL) || (fire && !done);

    // Phase and index of the step about to be computed
    always_comb begin
        nst = st_q;
        nk  = k_q + 1'b1;
        if (st_q == LOAD) begin
            nst = ENC;
            nk  = '0;
        end else if (st_q == ENC && k_q == KL) begin
            nst = TAIL1;
            nk  = '0;
        end else if (st_q == TAIL1 && k_q == TL) begin
            nst = TAIL2;
            nk  = '0;
        end
    end

    always_comb begin
        pi_sum = pi_q + g_q;
        g_sum  = g_q + DG;
        pi_d   = pi_sum >= KW ? pi_sum - KW : pi_sum;
        g_d    = g_sum >= KW ? g_sum - KW : g_sum;
        u1     = mem_q[nk[AW-1:0]];
        u2     = mem_q[pi_q[AW-1:0]];
    end

    rsc_enc u_rsc1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (step && nst != TAIL2),
        .term_i (nst == TAIL1),
        .clr_i  (st_q == LOAD && !step),
        .u_i    (u1),
        .sys_o  (sys1),
        .z_o    (z1)
    );

    rsc_enc u_rsc2 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (step && nst != TAIL1),
        .term_i (nst == TAIL2),
        .clr_i  (st_q == LOAD && !step),
        .u_i    (u2),
        .sys_o  (sys2),
        .z_o    (z2)
    );

    always_ff @(posedge clk) begin
        if (accept)
            mem_q[cnt_q[AW-1:0]] <= bus_if.in_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= LOAD;
            cnt_q  <= '0;
            k_q    <= '0;
            pi_q   <= '0;
            g_q    <= G0;
            ov_q   <= 1'b0;
            sys_q  <= 1'b0;
            p1_q   <= 1'b0;
            p2_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (accept)
                cnt_q <= cnt_q == KL ? '0 : cnt_q + 1'b1;
            if (step) begin
                st_q   <= nst;
                k_q    <= nk;
                ov_q   <= 1'b1;
                sys_q  <= nst == TAIL2 ? sys2 : sys1;
                p1_q   <= nst == TAIL2 ? 1'b0 : z1;
                p2_q   <= nst == TAIL1 ? 1'b0 : z2;
                last_q <= nst == TAIL2 && nk == TL;
            end else if (done) begin
                st_q   <= LOAD;
                k_q    <= '0;
                ov_q   <= 1'b0;
                sys_q  <= 1'b0;
                p1_q   <= 1'b0;
                p2_q   <= 1'b0;
                last_q <= 1'b0;
            end
            // Interleaver recursion is re-armed every idle LOAD cycle
            if (step && nst == ENC) begin
                pi_q <= pi_d;
                g_q  <= g_d;
            end else if (st_q == LOAD) begin
                pi_q <= '0;
                g_q  <= G0;
            end
        end
    end

    assign bus_if.in_ready  = st_q == LOAD;
    assign bus_if.busy      = st_q != LOAD;
    assign bus_if.out_valid = ov_q;
    assign bus_if.out_sys   = sys_q;
    assign bus_if.out_p1    = p1_q;
    assign bus_if.out_p2    = p2_q;
    assign bus_if.out_last  = last_q;
endmodule

// File: tb/tb_turbo_encode.sv
// tb_turbo_encode: directed and randomized checks of the turbo encoder block.
module tb_turbo_encode;
    localparam int K  = 40;
    localparam int F1 = 3;
    localparam int F2 = 10;
    localparam int N  = K + 6;

    typedef logic [N-1:0] tv_t;

    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;

    turbo_encode_if bus ();

    turbo_encode #(.K(K), .F1(F1), .F2(F2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [K-1:0] b, output tv_t es, output tv_t ep1, output tv_t ep2);
        logic [2:0] s1;
        logic [2:0] s2;
        logic       u;
        logic       a;
        int         pi;
        s1 = '0; s2 = '0; es = '0; ep1 = '0; ep2 = '0;
        for (int k = 0; k < K; k++) begin
            u = b[k];
            a = u ^ s1[1] ^ s1[0];
            es[k] = u;
            ep1[k] = a ^ s1[2] ^ s1[0];
            s1 = {a, s1[2:1]};
            pi = (F1 * k + F2 * k * k) % K;
            u = b[pi];
            a = u ^ s2[1] ^ s2[0];
            ep2[k] = a ^ s2[2] ^ s2[0];
            s2 = {a, s2[2:1]};
        end
        for (int t = 0; t < 3; t++) begin
            es[K+t] = s1[1] ^ s1[0];
            ep1[K+t] = s1[2] ^ s1[0];
            s1 = {1'b0, s1[2:1]};
            es[K+3+t] = s2[1] ^ s2[0];
            ep2[K+3+t] = s2[2] ^ s2[0];
            s2 = {1'b0, s2[2:1]};
        end
    endtask

    task automatic send(input logic [K-1:0] b, input int gap_pct, input bit hold, output int acc, output int irc);
        int  cyc;
        bit  took;
        acc = 0; irc = 0; cyc = 0;
        while (acc < K && cyc < 2000) begin
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.in_bit = b[acc];
            if (bus.in_ready === 1'b1) irc++;
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (took) acc++;
        end
        bus.in_valid = hold;
    endtask

    task automatic collect(input int rdy_pct, input bit iv_hold, output int n, output int herr, output int ierr,
                           output tv_t s, output tv_t p1, output tv_t p2, output tv_t l);
        logic [4:0] prev;
        bit         pv;
        bit         fin;
        int         cyc;
        n = 0; herr = 0; ierr = 0; s = '0; p1 = '0; p2 = '0; l = '0;
        pv = 0; fin = 0; cyc = 0; prev = '0;
        while (!fin && cyc < 2000) begin
            if (pv && {bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last} !== prev) herr++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) ierr++;
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            bus.in_valid = iv_hold ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_bit = 1'($urandom_range(0, 1));
            pv = bus.out_valid && !bus.out_ready;
            prev = {bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last};
            if (bus.out_valid === 1'b1 && bus.out_ready && n < N) begin
                s[n] = bus.out_sys; p1[n] = bus.out_p1; p2[n] = bus.out_p2; l[n] = bus.out_last;
                if (bus.out_last === 1'b1) fin = 1;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid = iv_hold;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checks++;
        if ({bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000", {bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last});
        checks++;
        if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++;
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if ({bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last} !== 5'b0) errs++;
    endtask

    task automatic test_all_zero;
        int  acc, irc, n, herr, ierr;
        tv_t s, p1, p2, l, el;
        el = '0; el[N-1] = 1'b1;
        send('0, 0, 0, acc, irc);
        checks++;
        if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL zero_latency: got out_valid=%b want 1", bus.out_valid); end
        collect(100, 0, n, herr, ierr, s, p1, p2, l);
        checks++;
        if (n !== N) begin errs++; $display("FAIL zero_count: got %0d want %0d", n, N); end
        checks++;
        if ((s | p1 | p2) !== '0) begin errs++; $display("FAIL zero_data: got %h want 0", s | p1 | p2); end
        checks++;
        if (l !== el) begin errs++; $display("FAIL zero_last: got %h want %h", l, el); end
        checks++;
        if (herr + ierr !== 0) begin errs++; $display("FAIL zero_busy: got %0d want 0", herr + ierr); end
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
            begin errs++; $display("FAIL zero_turnaround: got %b want 100", {bus.in_ready, bus.out_valid, bus.busy}); end
    endtask

    task automatic test_impulse0;
        int          acc, irc, n, herr, ierr;
        logic [K-1:0] b;
        tv_t         s, p1, p2, l, es, ep1, ep2;
        b = '0; b[0] = 1'b1;
        send(b, 20, 0, acc, irc);
        collect(70, 0, n, herr, ierr, s, p1, p2, l);
        model(b, es, ep1, ep2);
        checks++;
        if (p1[4:0] !== 5'b01111) begin errs++; $display("FAIL imp0_p1: got %b want 01111", p1[4:0]); end
        checks++;
        if (p2[4:0] !== 5'b01111) begin errs++; $display("FAIL imp0_p2: got %b want 01111", p2[4:0]); end
        checks++;
        if (s[K-1:0] !== b) begin errs++; $display("FAIL imp0_sys: got %h want %h", s[K-1:0], b); end
        checks++;
        if ({s, p1, p2} !== {es, ep1, ep2} || n !== N)
            begin errs++; $display("FAIL imp0_block: got %h %h %h want %h %h %h", s, p1, p2, es, ep1, ep2); end
    endtask

    task automatic test_impulse_pi;
        int          acc, irc, n, herr, ierr, first, fp1;
        int          pos [4] = '{13, 6, 19, 12};
        logic [K-1:0] b;
        tv_t         s, p1, p2, l;
        for (int i = 0; i < 4; i++) begin
            b = '0; b[pos[i]] = 1'b1;
            send(b, 0, 0, acc, irc);
            collect(100, 0, n, herr, ierr, s, p1, p2, l);
            first = -1; fp1 = -1;
            for (int k = K - 1; k >= 0; k--) begin
                if (p2[k]) first = k;
                if (p1[k]) fp1 = k;
            end
            checks++;
            if (first !== i + 1) begin errs++; $display("FAIL pi_seq_%0d: got first p2 at %0d want %0d", pos[i], first, i + 1); end
            checks++;
            if (s[K-1:0] !== b || fp1 !== pos[i])
                begin errs++; $display("FAIL imp_sys_%0d: got sys %h p1 first %0d want %h %0d", pos[i], s[K-1:0], fp1, b, pos[i]); end
        end
    endtask

    task automatic test_random;
        int          acc, irc, n, herr, ierr;
        logic [63:0] r;
        logic [K-1:0] b;
        tv_t         s, p1, p2, l, es, ep1, ep2, el;
        el = '0; el[N-1] = 1'b1;
        for (int blk = 0; blk < 200; blk++) begin
            r = {$urandom(), $urandom()};
            b = r[K-1:0];
            send(b, 30, 0, acc, irc);
            collect(60, 0, n, herr, ierr, s, p1, p2, l);
            model(b, es, ep1, ep2);
            checks++;
            if (acc !== K || n !== N) begin errs++; $display("FAIL rnd_count_%0d: got acc=%0d n=%0d want %0d %0d", blk, acc, n, K, N); end
            checks++;
            if ({s, p1, p2, l} !== {es, ep1, ep2, el})
                begin errs++; $display("FAIL rnd_data_%0d: got %h %h %h %h want %h %h %h %h", blk, s, p1, p2, l, es, ep1, ep2, el); end
            checks++;
            if (herr !== 0) begin errs++; $display("FAIL rnd_hold_%0d: got %0d want 0", blk, herr); end
            checks++;
            if (ierr !== 0) begin errs++; $display("FAIL rnd_in_ready_%0d: got %0d want 0", blk, ierr); end
        end
    endtask

    task automatic test_reset_mid;
        int          acc, irc, n, herr, ierr;
        logic [63:0] r;
        logic [K-1:0] b;
        tv_t         s, p1, p2, l, es, ep1, ep2;
        r = {$urandom(), $urandom()};
        b = r[K-1:0];
        send(b, 0, 0, acc, irc);
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        checks++;
        if ({bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last, bus.busy, bus.in_ready} !== 7'b0000001)
            begin errs++; $display("FAIL abort_outputs: got %b want 0000001",
                {bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_last, bus.busy, bus.in_ready}); end
        b = '1;
        send(b, 10, 0, acc, irc);
        collect(80, 0, n, herr, ierr, s, p1, p2, l);
        model(b, es, ep1, ep2);
        checks++;
        if ({s, p1, p2} !== {es, ep1, ep2} || n !== N)
            begin errs++; $display("FAIL abort_ones: got %h %h %h want %h %h %h", s, p1, p2, es, ep1, ep2); end
    endtask

    task automatic test_back_to_back;
        int          acc, irc, n, herr, ierr;
        logic [63:0] r;
        logic [K-1:0] b;
        tv_t         s, p1, p2, l, es, ep1, ep2;
        for (int blk = 0; blk < 2; blk++) begin
            r = {$urandom(), $urandom()};
            b = blk == 0 ? '1 : r[K-1:0];
            if (blk == 1) b[0] = 1'b0;
            send(b, 0, 1, acc, irc);
            checks++;
            if (irc !== K || acc !== K) begin errs++; $display("FAIL b2b_in_ready_%0d: got %0d cycles want %0d", blk, irc, K); end
            collect(100, 1, n, herr, ierr, s, p1, p2, l);
            model(b, es, ep1, ep2);
            checks++;
            if ({s, p1, p2} !== {es, ep1, ep2} || n !== N || ierr !== 0)
                begin errs++; $display("FAIL b2b_data_%0d: got %h %h %h want %h %h %h", blk, s, p1, p2, es, ep1, ep2); end
            if (blk == 1) begin
                checks++;
                if ({s[0], p1[0], p2[0]} !== 3'b000)
                    begin errs++; $display("FAIL b2b_first: got %b want 000", {s[0], p1[0], p2[0]}); end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_all_zero();
        test_impulse0();
        test_all_zero();
        test_impulse_pi();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
